sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// 32-bit load/store bridge onto a 16-bit asynchronous SRAM, one halfword per access state.
// Define SRAM_WAIT_STATE_EN to stretch each access state to two cycles for slower parts.
module sram_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic        op_wr_reg;
  logic [31:0] read_data_reg;

  logic        req;
  logic        step;
  logic        in_access;
  logic [31:0] offset;
  logic [16:0] word;
  logic        unused_bits;

  assign req       = rd_en | wr_en;
  assign in_access = (state_reg == ACC_LO) || (state_reg == ACC_HI);

  // SRAM data space starts at byte 1024; lower addresses wrap to the top of the part.
  assign offset      = addr_reg - 32'd1024;
  assign word        = offset[18:2];
  assign unused_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_WAIT_STATE_EN
  logic wait_reg, wait_next;

  // Advance only on the second cycle of each access state.
  assign step = wait_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_reg <= 1'b0;
    end else begin
      wait_reg <= wait_next;
    end
  end

  always_comb begin
    wait_next = 1'b0;
    if (in_access) begin
      wait_next = ~wait_reg;
    end
  end
`else
  assign step = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req)  state_next = ACC_LO;
      ACC_LO:  if (step) state_next = ACC_HI;
      ACC_HI:  if (step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is captured once on leaving IDLE; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
      op_wr_reg <= 1'b0;
    end else if (state_reg == IDLE && req) begin
      addr_reg  <= address;
      data_reg  <= writeData;
      op_wr_reg <= wr_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_reg <= 32'd0;
    end else if (!op_wr_reg && step) begin
      if (state_reg == ACC_LO) begin
        read_data_reg[15:0] <= SRAM_DQ_in;
      end else if (state_reg == ACC_HI) begin
        read_data_reg[31:16] <= SRAM_DQ_in;
      end
    end
  end

  assign readData = read_data_reg;

  // Output logic
  always_comb begin
    ready       = 1'b1;
    SRAM_ADDR   = 18'd0;
    SRAM_DQ_out = 16'd0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (state_reg)
      IDLE: begin
        ready = ~req;
      end
      ACC_LO: begin
        ready     = 1'b0;
        SRAM_ADDR = {word, 1'b0};
        if (op_wr_reg) begin
          SRAM_DQ_out = data_reg[15:0];
          SRAM_DQ_oe  = 1'b1;
          SRAM_WE_N   = 1'b0;
        end
      end
      ACC_HI: begin
        ready     = 1'b0;
        SRAM_ADDR = {word, 1'b1};
        if (op_wr_reg) begin
          SRAM_DQ_out = data_reg[31:16];
          SRAM_DQ_oe  = 1'b1;
          SRAM_WE_N   = 1'b0;
        end
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

endmodule
